// File: rtl/stream_sort_pkg.sv
// Shared types and width helpers for the streaming packet sorter.
package stream_sort_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  function automatic int count_width(input int max_length);
    return $clog2(max_length + 1);
  endfunction

  function automatic int index_width(input int max_length);
    return $clog2(max_length);
  endfunction

endpackage

// File: rtl/stream_sort_array.sv
// Sorted register array: one word inserted per cycle by parallel compare-and-shift.
module stream_sort_array
  import stream_sort_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LENGTH = 128,
  parameter int CW         = count_width(MAX_LENGTH),
  parameter int IW         = index_width(MAX_LENGTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  ins_en,
  input  logic [DATA_WIDTH-1:0] ins_data,
  input  logic [CW-1:0]         count,
  input  logic [IW-1:0]         rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [MAX_LENGTH];
  logic [MAX_LENGTH-1:0] gt;
  logic [CW-1:0]         fill;

  // A clearing insert treats the array as empty so the word lands in slot 0.
  assign fill = clear ? '0 : count;

  genvar i;
  generate
    for (i = 0; i < MAX_LENGTH; i++) begin : g_slot
      assign gt[i] = (CW'(i) < fill) && (mem[i] > ins_data);

      if (i == 0) begin : g_head
        always_ff @(posedge clock) begin
          if (!reset && ins_en && (gt[0] || fill == '0)) begin
            mem[0] <= ins_data;
          end
        end
      end else begin : g_body
        always_ff @(posedge clock) begin
          if (!reset && ins_en) begin
            if (gt[i-1]) begin
              mem[i] <= mem[i-1];
            end else if (gt[i] || CW'(i) == fill) begin
              mem[i] <= ins_data;
            end
          end
        end
      end
    end
  endgenerate

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/stream_sort.sv
// Packet sorter: insertion-sorts one sink packet, then streams it out ascending.
module stream_sort
  import stream_sort_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LENGTH = 128
) (
  input  logic                  snk_clock,
  input  logic                  snk_reset,
  output logic                  snk_ready,
  input  logic                  snk_valid,
  input  logic                  snk_sop,
  input  logic                  snk_eop,
  input  logic [DATA_WIDTH-1:0] snk_data,
  output logic                  src_valid,
  output logic                  src_sop,
  output logic                  src_eop,
  output logic [DATA_WIDTH-1:0] src_data
);

  localparam int CW = count_width(MAX_LENGTH);
  localparam int IW = index_width(MAX_LENGTH);

  state_t                state, state_d;
  logic [CW-1:0]         count;
  logic [IW-1:0]         rd_idx;
  logic                  drop;
  logic                  accept;
  logic                  ins_en;
  logic                  clear;
  logic                  last;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] rd_data;

  assign accept   = snk_valid && snk_ready;
  assign last     = (CW'(rd_idx) + CW'(1)) == count;
  // The word filling the final slot closes the packet even without eop.
  assign overflow = !snk_sop && !snk_eop && (count == CW'(MAX_LENGTH - 1));

  stream_sort_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_LENGTH (MAX_LENGTH),
    .CW         (CW),
    .IW         (IW)
  ) u_array (
    .clock    (snk_clock),
    .reset    (snk_reset),
    .clear    (clear),
    .ins_en   (ins_en),
    .ins_data (snk_data),
    .count    (count),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_d = state;
    ins_en  = 1'b0;
    clear   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && snk_sop) begin
          ins_en  = 1'b1;
          clear   = 1'b1;
          state_d = snk_eop ? OUTPUT : RECEIVE;
        end
      end
      RECEIVE: begin
        if (accept) begin
          ins_en = 1'b1;
          clear  = snk_sop;
          if (snk_eop || overflow) state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge snk_clock) begin
    if (snk_reset) begin
      state     <= IDLE;
      count     <= '0;
      rd_idx    <= '0;
      drop      <= 1'b0;
      snk_ready <= 1'b0;
      src_valid <= 1'b0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
      src_data  <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: begin
          snk_ready <= 1'b1;
          src_valid <= 1'b0;
          src_sop   <= 1'b0;
          src_eop   <= 1'b0;
          rd_idx    <= '0;
          if (accept) begin
            if (snk_sop) begin
              drop  <= 1'b0;
              count <= CW'(1);
              if (snk_eop) snk_ready <= 1'b0;
            end else if (snk_eop && drop) begin
              drop <= 1'b0;
            end
          end
        end
        RECEIVE: begin
          if (accept) begin
            count <= snk_sop ? CW'(1) : count + CW'(1);
            if (state_d == OUTPUT) snk_ready <= 1'b0;
            if (overflow) drop <= 1'b1;
          end
        end
        OUTPUT: begin
          src_valid <= 1'b1;
          src_sop   <= (rd_idx == '0);
          src_eop   <= last;
          src_data  <= rd_data;
          rd_idx    <= rd_idx + IW'(1);
          if (last) begin
            snk_ready <= 1'b1;
            count     <= '0;
            rd_idx    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sort.sv
// Self-checking bench for stream_sort: directed vector table plus random packets vs a sorting model.
module tb_stream_sort;

  logic        snk_clock = 1'b0;
  logic        snk_reset;
  logic        snk_ready;
  logic        snk_valid;
  logic        snk_sop;
  logic        snk_eop;
  logic [15:0] snk_data;
  logic        src_valid;
  logic        src_sop;
  logic        src_eop;
  logic [15:0] src_data;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]        n;
    logic [7:0][15:0]  d;
    logic [7:0]        sop;
    logic [7:0]        eop;
    logic [3:0]        en;
    logic [7:0][15:0]  e;
  } vec_t;

  vec_t vecs [5];

  stream_sort #(.DATA_WIDTH(16), .MAX_LENGTH(128)) dut (
    .snk_clock (snk_clock),
    .snk_reset (snk_reset),
    .snk_ready (snk_ready),
    .snk_valid (snk_valid),
    .snk_sop   (snk_sop),
    .snk_eop   (snk_eop),
    .snk_data  (snk_data),
    .src_valid (src_valid),
    .src_sop   (src_sop),
    .src_eop   (src_eop),
    .src_data  (src_data)
  );

  always #5 snk_clock = ~snk_clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Presents one beat and holds it until the sorter accepts it.
  task automatic send(input logic [15:0] d, input logic s, input logic e);
    int t;
    snk_valid = 1'b1;
    snk_data  = d;
    snk_sop   = s;
    snk_eop   = e;
    t = 0;
    @(negedge snk_clock);
    while (!snk_ready && t < 500) begin
      @(negedge snk_clock);
      t++;
    end
    if (!snk_ready) chk("send_timeout", 32'(t), 32'd0);
    @(posedge snk_clock);
    #1;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  // Called right after the closing beat is accepted; checks the whole source packet.
  task automatic collect(input logic [15:0] exp[$], input string name);
    int t;
    int n;
    n = exp.size();
    @(negedge snk_clock);
    chk({name, "_ready_low"}, 32'(snk_ready), 32'd0);
    t = 0;
    while (!src_valid && t < 300) begin
      @(negedge snk_clock);
      t++;
    end
    chk({name, "_latency"}, 32'(t), 32'd1);
    if (src_valid) begin
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge snk_clock);
        chk({name, "_valid"}, 32'(src_valid), 32'd1);
        chk({name, "_data"},  32'(src_data), 32'(exp[k]));
        chk({name, "_sop"},   32'(src_sop), 32'(k == 0));
        chk({name, "_eop"},   32'(src_eop), 32'(k == n - 1));
        chk({name, "_ready"}, 32'(snk_ready), 32'(k == n - 1));
      end
      @(negedge snk_clock);
      chk({name, "_end"}, 32'(src_valid), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] ex[$];

    vecs[0] = '{n: 4'd5, d: {16'h0, 16'h0, 16'h0, 16'h3, 16'h2, 16'h4, 16'h1, 16'h5},
                sop: 8'b0000_0001, eop: 8'b0001_0000, en: 4'd5,
                e: {16'h0, 16'h0, 16'h0, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1}};
    vecs[1] = '{n: 4'd1, d: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hBEEF},
                sop: 8'b0000_0001, eop: 8'b0000_0001, en: 4'd1,
                e: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hBEEF}};
    vecs[2] = '{n: 4'd5, d: {16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h8000, 16'h0, 16'hFFFF},
                sop: 8'b0000_0001, eop: 8'b0001_0000, en: 4'd5,
                e: {16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0, 16'h0}};
    vecs[3] = '{n: 4'd5, d: {16'h0, 16'h0, 16'h0, 16'h2, 16'h3, 16'h7, 16'h8, 16'h9},
                sop: 8'b0000_1001, eop: 8'b0001_0000, en: 4'd2,
                e: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3, 16'h2}};
    vecs[4] = '{n: 4'd3, d: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4, 16'h6, 16'h11},
                sop: 8'b0000_0010, eop: 8'b0000_0100, en: 4'd2,
                e: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h6, 16'h4}};

    snk_reset = 1'b1;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    snk_data  = '0;
    repeat (3) @(negedge snk_clock);
    chk("rst_ready", 32'(snk_ready), 32'd0);
    chk("rst_valid", 32'(src_valid), 32'd0);
    chk("rst_sop",   32'(src_sop), 32'd0);
    chk("rst_eop",   32'(src_eop), 32'd0);
    chk("rst_data",  32'(src_data), 32'd0);
    snk_reset = 1'b0;
    @(negedge snk_clock);
    chk("ready_after_rst", 32'(snk_ready), 32'd1);

    // Reset in the middle of an output burst clears the source on that edge.
    send(16'd7, 1'b1, 1'b0);
    send(16'd6, 1'b0, 1'b0);
    send(16'd5, 1'b0, 1'b1);
    @(negedge snk_clock);
    @(negedge snk_clock);
    chk("midrst_pre_valid", 32'(src_valid), 32'd1);
    snk_reset = 1'b1;
    @(posedge snk_clock);
    #1;
    chk("midrst_valid", 32'(src_valid), 32'd0);
    chk("midrst_ready", 32'(snk_ready), 32'd0);
    snk_reset = 1'b0;
    @(posedge snk_clock);
    #1;
    chk("midrst_ready_back", 32'(snk_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < int'(vecs[v].n); i++)
        send(vecs[v].d[i], vecs[v].sop[i], vecs[v].eop[i]);
      ex.delete();
      for (int i = 0; i < int'(vecs[v].en); i++) ex.push_back(vecs[v].e[i]);
      collect(ex, $sformatf("vec%0d", v));
    end

    for (int p = 0; p < 8; p++) begin
      int len;
      len = int'($urandom_range(2, 128));
      q.delete();
      for (int i = 0; i < len; i++)
        q.push_back((p % 2 == 1) ? 16'($urandom & 32'hF) : 16'($urandom));
      for (int i = 0; i < len; i++) send(q[i], i == 0, i == len - 1);
      ex = q;
      ex.sort();
      collect(ex, $sformatf("rnd%0d", p));
    end

    // Overflow: only the first 128 words are kept; the two extra words are dropped.
    q.delete();
    for (int i = 0; i < 130; i++) q.push_back(16'($urandom));
    for (int i = 0; i < 128; i++) send(q[i], i == 0, 1'b0);
    ex = q[0:127];
    ex.sort();
    fork
      begin
        send(q[128], 1'b0, 1'b0);
        send(q[129], 1'b0, 1'b1);
      end
      collect(ex, "ovf");
    join
    for (int i = 0; i < 4; i++) begin
      @(negedge snk_clock);
      chk("ovf_dropped", 32'(src_valid), 32'd0);
    end
    send(16'd10, 1'b1, 1'b0);
    send(16'd50, 1'b0, 1'b0);
    send(16'd30, 1'b0, 1'b0);
    send(16'd20, 1'b0, 1'b0);
    send(16'd40, 1'b0, 1'b1);
    ex = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    collect(ex, "post_ovf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
